// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared types and constants for the AER input receiver
package aer_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } aer_in_state_t;

    localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/aer_evt_fifo.sv
// rtl/aer_evt_fifo.sv - synchronous show-ahead event FIFO with occupancy count
module aer_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    // Writes into a full FIFO and reads from an empty one are ignored.
    assign push_en   = push && !full;
    assign pop_en    = pop && !empty;
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign head_data = mem[rd_ptr];

    // Storage, pointers (power-of-two depth wraps naturally) and occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aer_in_dec.sv
// rtl/aer_in_dec.sv - AER 4-phase receiver with event FIFO; option AERIN_ADDR_CHECK_EN drops out-of-range addresses
module aer_in_dec
    import aer_pkg::*;
#(
    parameter int IMAGE_SIZE      = 5,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [IMAGE_SIZE_BITS:0] AERIN_ADDR,
    input  logic                     AERIN_REQ,
    output logic                     AERIN_ACK,
    output logic [IMAGE_SIZE_BITS:0] EVT_ADDR,
    output logic                     EVT_VALID,
    input  logic                     EVT_READY,
    output logic [FIFO_AW:0]         FIFO_COUNT
`ifdef AERIN_ADDR_CHECK_EN
    ,
    output logic [DROP_CNT_W-1:0]    DROP_CNT
`endif
);

    // Reject configurations the FIFO pointer arithmetic and address width cannot represent.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        IMAGE_SIZE < 1 || IMAGE_SIZE > (1 << (IMAGE_SIZE_BITS + 1))) begin : g_param_err
        $error("aer_in_dec: unsupported IMAGE_SIZE/FIFO_DEPTH combination");
    end

    aer_in_state_t state;
    aer_in_state_t state_nxt;
    logic          ack_nxt;
    logic          req_s1;
    logic          req_s;
    logic          push;
    logic          fifo_empty;
    logic          fifo_full;
    logic          drop_inc;
    logic          addr_ok;

`ifdef AERIN_ADDR_CHECK_EN
    localparam logic [IMAGE_SIZE_BITS:0] ADDR_LIMIT = (IMAGE_SIZE_BITS+1)'(IMAGE_SIZE);
    assign addr_ok = (AERIN_ADDR < ADDR_LIMIT);
`else
    assign addr_ok = 1'b1;
`endif

    // Two-flop synchronizer for the asynchronous request; ADDR is already settled by the time req_s rises.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_s1 <= 1'b0;
            req_s  <= 1'b0;
        end else begin
            req_s1 <= AERIN_REQ;
            req_s  <= req_s1;
        end
    end

    // Handshake state and registered acknowledge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            AERIN_ACK <= 1'b0;
        end else begin
            state     <= state_nxt;
            AERIN_ACK <= ack_nxt;
        end
    end

    // One capture per handshake; a full FIFO holds ACK low, a rejected address is acknowledged without a push.
    always_comb begin
        state_nxt = state;
        ack_nxt   = AERIN_ACK;
        push      = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                ack_nxt = 1'b0;
                if (req_s) begin
                    if (!addr_ok) begin
                        drop_inc  = 1'b1;
                        ack_nxt   = 1'b1;
                        state_nxt = ACK_HI;
                    end else if (!fifo_full) begin
                        push      = 1'b1;
                        ack_nxt   = 1'b1;
                        state_nxt = ACK_HI;
                    end
                end
            end
            ACK_HI: begin
                ack_nxt = 1'b1;
                if (!req_s) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                ack_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef AERIN_ADDR_CHECK_EN
    // Count rejected events, holding at the maximum rather than wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DROP_CNT <= '0;
        end else if (drop_inc && DROP_CNT != '1) begin
            DROP_CNT <= DROP_CNT + 1'b1;
        end
    end
`endif

    aer_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW),
        .W     (IMAGE_SIZE_BITS + 1)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (AERIN_ADDR),
        .pop       (EVT_READY),
        .head_data (EVT_ADDR),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (FIFO_COUNT)
    );

    assign EVT_VALID = !fifo_empty;

`ifndef AERIN_ADDR_CHECK_EN
    logic unused_drop;
    assign unused_drop = drop_inc;
`endif

endmodule

// File: tb/tb_aer_in_dec.sv
// tb/tb_aer_in_dec.sv - self-checking bench for aer_in_dec; define AERIN_ADDR_CHECK_EN to cover address rejection
module tb_aer_in_dec;
    import aer_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] AERIN_ADDR = '0;
    logic       AERIN_REQ = 1'b0;
    logic       AERIN_ACK;
    logic [3:0] EVT_ADDR;
    logic       EVT_VALID;
    logic       EVT_READY = 1'b0;
    logic [2:0] FIFO_COUNT;
`ifdef AERIN_ADDR_CHECK_EN
    logic [7:0] DROP_CNT;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic       log_en = 1'b0;
    logic [3:0] log_q[$];

    always #5 CLK = ~CLK;

    aer_in_dec #(
        .IMAGE_SIZE (5),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .AERIN_ADDR (AERIN_ADDR),
        .AERIN_REQ  (AERIN_REQ),
        .AERIN_ACK  (AERIN_ACK),
        .EVT_ADDR   (EVT_ADDR),
        .EVT_VALID  (EVT_VALID),
        .EVT_READY  (EVT_READY),
        .FIFO_COUNT (FIFO_COUNT)
`ifdef AERIN_ADDR_CHECK_EN
        ,
        .DROP_CNT   (DROP_CNT)
`endif
    );

    always @(posedge CLK) begin
        if (log_en && EVT_VALID && EVT_READY) log_q.push_back(EVT_ADDR);
    end

    typedef struct {
        logic       rst;
        logic       req;
        logic [3:0] addr;
        logic       rdy;
        logic       ack;
        logic       valid;
        logic [3:0] eaddr;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ack(input logic lvl, input string nm);
        int n = 0;
        while (AERIN_ACK !== lvl && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check(nm, AERIN_ACK, lvl);
    endtask

    task automatic send_evt(input logic [3:0] a);
        @(negedge CLK);
        AERIN_ADDR = a;
        AERIN_REQ  = 1'b1;
        wait_ack(1'b1, "sender_ack_rise");
        AERIN_REQ = 1'b0;
        wait_ack(1'b0, "sender_ack_fall");
    endtask

    task automatic pop_one(input logic [3:0] exp_addr, input string nm);
        check(nm, EVT_ADDR, exp_addr);
        EVT_READY = 1'b1;
        @(negedge CLK);
        EVT_READY = 1'b0;
    endtask

    initial begin
        //           rst req addr rdy  ack val ea cnt
        tbl[0]  = '{1, 0, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{0, 1, 3, 0,  0, 0, 0, 0};
        tbl[2]  = '{0, 1, 3, 0,  0, 0, 0, 0};
        tbl[3]  = '{0, 1, 3, 0,  1, 1, 3, 1};
        tbl[4]  = '{0, 1, 3, 0,  1, 1, 3, 1};
        tbl[5]  = '{0, 0, 3, 0,  1, 1, 3, 1};
        tbl[6]  = '{0, 0, 3, 0,  1, 1, 3, 1};
        tbl[7]  = '{0, 0, 3, 0,  0, 1, 3, 1};
        tbl[8]  = '{0, 0, 3, 1,  0, 0, 0, 0};
        tbl[9]  = '{0, 0, 3, 1,  0, 0, 0, 0};
        tbl[10] = '{0, 1, 4, 0,  0, 0, 0, 0};
        tbl[11] = '{0, 1, 4, 0,  0, 0, 0, 0};
        tbl[12] = '{0, 1, 4, 0,  1, 1, 4, 1};
        tbl[13] = '{0, 0, 4, 1,  1, 0, 0, 0};
        tbl[14] = '{0, 0, 4, 0,  1, 0, 0, 0};
        tbl[15] = '{0, 0, 4, 0,  0, 0, 0, 0};

        repeat (2) @(negedge CLK);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            RST        = tbl[i].rst;
            AERIN_REQ  = tbl[i].req;
            AERIN_ADDR = tbl[i].addr;
            EVT_READY  = tbl[i].rdy;
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_ack", i),   AERIN_ACK,  tbl[i].ack);
            check($sformatf("vec%0d_valid", i), EVT_VALID,  tbl[i].valid);
            check($sformatf("vec%0d_addr", i),  EVT_ADDR,   tbl[i].eaddr);
            check($sformatf("vec%0d_count", i), FIFO_COUNT, tbl[i].cnt);
        end
        @(negedge CLK);
        EVT_READY = 1'b0;
        AERIN_REQ = 1'b0;

        // Back-to-back handshakes with a draining consumer.
        EVT_READY = 1'b1;
        log_en    = 1'b1;
        send_evt(4'd0);
        send_evt(4'd1);
        send_evt(4'd2);
        send_evt(4'd4);
        repeat (4) @(negedge CLK);
        log_en    = 1'b0;
        EVT_READY = 1'b0;
        check("b2b_log_size", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("b2b_log0", log_q[0], 0);
            check("b2b_log1", log_q[1], 1);
            check("b2b_log2", log_q[2], 2);
            check("b2b_log3", log_q[3], 4);
        end
        check("b2b_count", FIFO_COUNT, 0);

        // Backpressure: fill the FIFO, fifth request must wait for a pop.
        send_evt(4'd0);
        send_evt(4'd1);
        send_evt(4'd2);
        send_evt(4'd3);
        check("bp_full_count", FIFO_COUNT, 4);
        @(negedge CLK);
        AERIN_ADDR = 4'd4;
        AERIN_REQ  = 1'b1;
        repeat (8) @(negedge CLK);
        check("bp_ack_held_low", AERIN_ACK, 0);
        check("bp_count_held", FIFO_COUNT, 4);
        pop_one(4'd0, "bp_first_head");
        wait_ack(1'b1, "bp_fifth_ack");
        check("bp_count_after", FIFO_COUNT, 4);
        AERIN_REQ = 1'b0;
        wait_ack(1'b0, "bp_fifth_ack_fall");
        for (int i = 0; i < 4; i++) begin
            pop_one(4'(i + 1), $sformatf("bp_drain%0d", i));
        end
        check("bp_drained", FIFO_COUNT, 0);

        // Simultaneous push and pop at count 2.
        send_evt(4'd2);
        send_evt(4'd3);
        check("pp_count_pre", FIFO_COUNT, 2);
        @(negedge CLK);
        AERIN_ADDR = 4'd0;
        AERIN_REQ  = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        EVT_READY = 1'b1;
        @(negedge CLK);
        EVT_READY = 1'b0;
        check("pp_ack", AERIN_ACK, 1);
        check("pp_count", FIFO_COUNT, 2);
        check("pp_head", EVT_ADDR, 3);
        AERIN_REQ = 1'b0;
        wait_ack(1'b0, "pp_ack_fall");
        pop_one(4'd3, "pp_drain0");
        pop_one(4'd0, "pp_drain1");
        check("pp_empty", EVT_VALID, 0);

        // Reset while ACK is high.
        @(negedge CLK);
        AERIN_ADDR = 4'd1;
        AERIN_REQ  = 1'b1;
        wait_ack(1'b1, "rst_ack_rise");
        #2;
        RST = 1'b1;
        #1;
        check("rst_ack", AERIN_ACK, 0);
        check("rst_valid", EVT_VALID, 0);
        check("rst_count", FIFO_COUNT, 0);
        check("rst_addr", EVT_ADDR, 0);
        check("rst_state_idle", (dut.state == IDLE), 1);
        AERIN_REQ = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_no_recapture", FIFO_COUNT, 0);

`ifdef AERIN_ADDR_CHECK_EN
        // Out-of-range addresses are acknowledged but never stored.
        send_evt(4'd6);
        check("chk_count", FIFO_COUNT, 0);
        check("chk_drop1", DROP_CNT, 1);
        for (int i = 0; i < 299; i++) send_evt(4'd7);
        check("chk_drop_sat", DROP_CNT, 255);
        check("chk_count_end", FIFO_COUNT, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
